// File: rtl/img_lk_pkg.sv
// Shared types and constants for the Lucas-Kanade gradient front-end.
package img_lk_pkg;

  // Kernel select; RESERVED behaves exactly like SOBEL.
  typedef enum logic [1:0] {
    SOBEL    = 2'd0,
    SCHARR   = 2'd1,
    CENTRAL  = 2'd2,
    RESERVED = 2'd3
  } mode_t;

  // Outer-row/column and centre-row/column weights of each kernel.
  localparam logic [3:0] W_SOBEL_OUTER    = 4'd1;
  localparam logic [3:0] W_SOBEL_CENTRE   = 4'd2;
  localparam logic [3:0] W_SCHARR_OUTER   = 4'd3;
  localparam logic [3:0] W_SCHARR_CENTRE  = 4'd10;
  localparam logic [3:0] W_CENTRAL_OUTER  = 4'd0;
  localparam logic [3:0] W_CENTRAL_CENTRE = 4'd1;

  // Headroom above the pixel width: +1 frame sum, +1 sign of the difference,
  // +4 for the weight sum of 16 (Scharr), +1 spare.
  localparam int INT_GUARD_BITS = 7;

  typedef struct packed {
    logic [3:0] outer;
    logic [3:0] centre;
  } kernel_w_t;

  function automatic int int_bits(input int raw_bits);
    return raw_bits + INT_GUARD_BITS;
  endfunction

  function automatic kernel_w_t kernel_weights(input mode_t mode);
    kernel_w_t kw;
    case (mode)
      SCHARR:  begin kw.outer = W_SCHARR_OUTER;  kw.centre = W_SCHARR_CENTRE;  end
      CENTRAL: begin kw.outer = W_CENTRAL_OUTER; kw.centre = W_CENTRAL_CENTRE; end
      default: begin kw.outer = W_SOBEL_OUTER;   kw.centre = W_SOBEL_CENTRE;   end
    endcase
    return kw;
  endfunction

endpackage

// File: rtl/img_lk_grad_sat.sv
// Arithmetic right shift (floor rounding) followed by a signed clamp to
// OUT_BITS; sat flags that the clamp engaged.
module img_lk_grad_sat #(
  parameter int IN_BITS  = 15,
  parameter int OUT_BITS = 12,
  parameter int SHIFT    = 0
) (
  input  logic [IN_BITS-1:0]  x,
  output logic [OUT_BITS-1:0] y,
  output logic                sat
);

  // One bit wider than either side so both limits are representable.
  localparam int W = ((IN_BITS > OUT_BITS) ? IN_BITS : OUT_BITS) + 1;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] x_ext;
  logic signed [W-1:0] x_sh;

  // Sign-extend, shift, then clamp to the output range.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    y     = '0;
    sat   = 1'b0;
    x_ext = {{(W-IN_BITS){x[IN_BITS-1]}}, x};
    x_sh  = x_ext >>> SHIFT;
    if (x_sh > MAX_V) begin
      y   = MAX_V[OUT_BITS-1:0];
      sat = 1'b1;
    end else if (x_sh < MIN_V) begin
      y   = MIN_V[OUT_BITS-1:0];
      sat = 1'b1;
    end else begin
      y   = x_sh[OUT_BITS-1:0];
    end
  end

endmodule

// File: rtl/img_lk_gradient.sv
// Gradient front-end for Lucas-Kanade: temporal difference and selectable
// spatial gradients over a 3x3 two-frame window, 5-stage fixed latency.
module img_lk_gradient
  import img_lk_pkg::*;
#(
  parameter int RAW_BITS  = 8,
  parameter int GRAD_BITS = RAW_BITS + 4,
  parameter int OUT_SHIFT = 0,
  parameter int USER_BITS = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cke,
  input  logic                                 s_valid,
  input  logic [USER_BITS-1:0]                 s_user,
  input  logic [1:0]                           s_mode,
  input  logic [2:0][2:0][1:0][RAW_BITS-1:0]   s_raw,
  output logic                                 m_valid,
  output logic [USER_BITS-1:0]                 m_user,
  output logic [1:0][RAW_BITS-1:0]             m_raw,
  output logic [GRAD_BITS-1:0]                 m_diff,
  output logic [GRAD_BITS-1:0]                 m_gradx,
  output logic [GRAD_BITS-1:0]                 m_grady,
  output logic                                 m_sat,
  output logic [15:0]                          frame_sat_count
);

  localparam int INT_BITS = int_bits(RAW_BITS);
  localparam int SUM_BITS = RAW_BITS + 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef logic signed [INT_BITS-1:0] int_t;

  function automatic int_t zext(input logic [SUM_BITS-1:0] v);
    return int_t'({{(INT_BITS-SUM_BITS){1'b0}}, v});
  endfunction

  // Constant-weight product built from shifted copies of x, one per set
  // weight bit; weights never exceed 4 bits.
  function automatic int_t w_mul(input int_t x, input logic [3:0] w);
    int_t acc;
    acc = '0;
    for (int b = 0; b < 4; b++) begin
      if (w[b]) acc = acc + (x <<< b);
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------- mode
  logic  frame_start_in;
  mode_t mode_q;
  mode_t in_mode;

  assign frame_start_in = s_valid & s_user[0];

  // A frame-start window uses its own s_mode; later windows reuse the latch.
  always_comb begin
    in_mode = mode_q;
    if (frame_start_in) in_mode = mode_t'(s_mode);
  end

  // Mode latch, updated only on an accepted frame-start window.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n)                  mode_q <= SOBEL;
    else if (cke & frame_start_in) mode_q <= mode_t'(s_mode);
  end

  // ------------------------------------------------------ sideband stages
  logic [3:0]                          v_q;
  logic [3:0][USER_BITS-1:0]           u_q;
  mode_t                               md_q [4];
  logic [3:0][1:0][RAW_BITS-1:0]       c_q;
  int_t                                df_q [4];

  // Valid, user, mode, centre pixel and temporal difference travel together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      u_q <= '0;
      c_q <= '0;
      for (int i = 0; i < 4; i++) begin
        md_q[i] <= SOBEL;
        df_q[i] <= '0;
      end
    end else if (cke) begin
      v_q[0]  <= s_valid;
      u_q[0]  <= s_valid ? s_user : '0;
      md_q[0] <= in_mode;
      c_q[0]  <= s_raw[1][1];
      df_q[0] <= zext({1'b0, s_raw[1][1][1]}) - zext({1'b0, s_raw[1][1][0]});
      for (int i = 1; i < 4; i++) begin
        v_q[i]  <= v_q[i-1];
        u_q[i]  <= u_q[i-1];
        md_q[i] <= md_q[i-1];
        c_q[i]  <= c_q[i-1];
        df_q[i] <= df_q[i-1];
      end
    end
  end

  // ------------------------------------------------------ datapath stages
  logic [2:0][2:0][SUM_BITS-1:0] m_q;
  int_t                          dx_q [3];
  int_t                          dy_q [3];
  int_t                          tx_q [3];
  int_t                          ty_q [3];
  int_t                          tx_d [3];
  int_t                          ty_d [3];
  int_t                          gx_q;
  int_t                          gy_q;
  kernel_w_t                     kw;

  // Weight each row/column difference for the mode carried with stage 1.
  always_comb begin
    kw = kernel_weights(md_q[1]);
    for (int i = 0; i < 3; i++) begin
      tx_d[i] = w_mul(dx_q[i], (i == 1) ? kw.centre : kw.outer);
      ty_d[i] = w_mul(dy_q[i], (i == 1) ? kw.centre : kw.outer);
    end
  end

  // Stage 0 frame sums, stage 1 differences, stage 2 weights, stage 3 sums.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q  <= '0;
      gx_q <= '0;
      gy_q <= '0;
      for (int i = 0; i < 3; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
        tx_q[i] <= '0;
        ty_q[i] <= '0;
      end
    end else if (cke) begin
      for (int y = 0; y < 3; y++) begin
        for (int x = 0; x < 3; x++) begin
          m_q[y][x] <= {1'b0, s_raw[y][x][0]} + {1'b0, s_raw[y][x][1]};
        end
      end
      for (int i = 0; i < 3; i++) begin
        dx_q[i] <= zext(m_q[i][2]) - zext(m_q[i][0]);
        dy_q[i] <= zext(m_q[2][i]) - zext(m_q[0][i]);
        tx_q[i] <= tx_d[i];
        ty_q[i] <= ty_d[i];
      end
      gx_q <= tx_q[0] + tx_q[1] + tx_q[2];
      gy_q <= ty_q[0] + ty_q[1] + ty_q[2];
    end
  end

  // ------------------------------------------------------- stage 4: clamp
  logic [GRAD_BITS-1:0] diff_c, gx_c, gy_c;
  logic                 diff_sat, gx_sat, gy_sat;

  img_lk_grad_sat #(.IN_BITS(INT_BITS), .OUT_BITS(GRAD_BITS), .SHIFT(0)) u_sat_diff (
    .x   (df_q[3]),
    .y   (diff_c),
    .sat (diff_sat)
  );

  img_lk_grad_sat #(.IN_BITS(INT_BITS), .OUT_BITS(GRAD_BITS), .SHIFT(OUT_SHIFT)) u_sat_gx (
    .x   (gx_q),
    .y   (gx_c),
    .sat (gx_sat)
  );

  img_lk_grad_sat #(.IN_BITS(INT_BITS), .OUT_BITS(GRAD_BITS), .SHIFT(OUT_SHIFT)) u_sat_gy (
    .x   (gy_q),
    .y   (gy_c),
    .sat (gy_sat)
  );

  // Output register; user is forced to 0 on idle beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_user  <= '0;
      m_raw   <= '0;
      m_diff  <= '0;
      m_gradx <= '0;
      m_grady <= '0;
      m_sat   <= 1'b0;
    end else if (cke) begin
      m_valid <= v_q[3];
      m_user  <= v_q[3] ? u_q[3] : '0;
      m_raw   <= c_q[3];
      m_diff  <= diff_c;
      m_gradx <= gx_c;
      m_grady <= gy_c;
      m_sat   <= v_q[3] & (diff_sat | gx_sat | gy_sat);
    end
  end

  // ------------------------------------------------- saturation counter
  logic [15:0] run_cnt;
  logic        in_frame;

  // Count saturated output beats; a frame-start beat publishes the running
  // count and restarts it. Beats before the first frame start are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt         <= '0;
      frame_sat_count <= '0;
      in_frame        <= 1'b0;
    end else if (cke & m_valid) begin
      if (m_user[0]) begin
        frame_sat_count <= run_cnt;
        run_cnt         <= {15'd0, m_sat};
        in_frame        <= 1'b1;
      end else if (in_frame & m_sat & (run_cnt != CNT_MAX)) begin
        run_cnt <= run_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/img_lk_gradient.md
# img_lk_gradient

Parametrised successor gradient front-end for the Lucas-Kanade optical-flow pipeline. It takes a 3x3 window from two consecutive frames (previous and current) with a valid/user sideband. It produces the temporal difference and the spatial gradients gx and gy. The spatial kernel is selected at run time (Sobel, Scharr or central difference) and is latched per frame. Outputs are scaled, saturated and flagged, and a per-frame saturation count is kept. It sits between the window line-buffer and the LK structure-tensor accumulator.

## Interface
- RAW_BITS, 8: pixel width, unsigned.
- GRAD_BITS, RAW_BITS+4: signed output width of diff/gx/gy.
- OUT_SHIFT, 0: arithmetic right shift applied to gx/gy before saturation. It is not applied to diff.
- USER_BITS, 1: sideband width. user[0] = frame start.
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous, active-low reset.
- cke, input, 1: clock enable. When low, every register holds, including the mode and counter registers.
- s_valid, input, 1: input window valid.
- s_user, input, USER_BITS: sideband travelling with the window.
- s_mode, input, 2: kernel select. 0 = Sobel, 1 = Scharr, 2 = central difference, 3 = reserved (treated as Sobel).
- s_raw, input, [2:0][2:0][1:0] x RAW_BITS: window indexed [y][x][f], where f=1 is the current frame and f=0 is the previous frame.
- m_valid, output, 1: output valid.
- m_user, output, USER_BITS: delayed s_user.
- m_raw, output, [1:0] x RAW_BITS: centre pixel s_raw[1][1], both frames.
- m_diff, output, GRAD_BITS: cur - prev of the centre pixel, saturated.
- m_gradx, output, GRAD_BITS: horizontal gradient.
- m_grady, output, GRAD_BITS: vertical gradient.
- m_sat, output, 1: set when any of diff/gx/gy saturated for this pixel.
- frame_sat_count, output, 16: number of saturated pixels in the last completed frame.

## Operation
- The pipeline advances only when cke=1. Valid, user, raw and mode are all carried through the same stages.
- **Mode latch:** s_mode is captured when cke & s_valid & s_user[0].
  - The captured mode applies to that window and to every window after it until the next frame start.
  - s_mode changes mid-frame are ignored.
  - The mode is carried in the pipeline alongside each window, so the latency is the same for every mode.
- **Stage 0:** frame sums m[y][x] = prev + cur. Each sum is RAW_BITS+1 bits, unsigned.
- **Stages 1-3:** arithmetic is signed, with INT_BITS = RAW_BITS+7 internal width so there is no overflow. Define dx_r = m[r][2] - m[r][0] and dy_c = m[2][c] - m[0][c].
  - Sobel: gx = dx_0 + 2*dx_1 + dx_2. gy = dy_0 + 2*dy_1 + dy_2.
  - Scharr: gx = 3*dx_0 + 10*dx_1 + 3*dx_2. gy uses the same weights on dy.
  - Central difference: gx = dx_1. gy = dy_1.
  - All constant weights are implemented with shift-and-add. No multipliers are inferred.
- **Stage 4:** gx/gy are arithmetic-right-shifted by OUT_SHIFT, which rounds toward negative infinity. diff/gx/gy are then clamped to [-2^(GRAD_BITS-1), 2^(GRAD_BITS-1)-1]. m_sat is the OR of the three clamp events.
- **Saturation counter:** updates on each output beat (m_valid & cke).
  - If m_user[0] is set: frame_sat_count <= running count, and the running count <= m_sat.
  - Otherwise: running count += m_sat.
  - Both saturate at 0xFFFF.
- **Data with m_valid=0:** outputs carry don't-care data. m_user is 0 when m_valid is 0.

## Timing
- Latency is 5 cke-qualified cycles from s_valid to m_valid, fixed for all modes.
- Throughput is one window per enabled cycle. There is no backpressure; cke is the only stall.
- **Reset:** all valid bits, outputs and counters go to 0, and the mode register goes to Sobel.
  - Reset asserted mid-frame drops all in-flight windows.
  - The running count restarts at 0.
- **Frame start at the input and output in the same cycle:** the input side latches the new mode. The output side closes the previous frame's count independently.
- **First frame after reset:** frame_sat_count stays 0 until the first output frame-start beat. That beat publishes a count of 0.

## Structure
- Package img_lk_pkg holds:
  - the mode_t enum (SOBEL, SCHARR, CENTRAL, RESERVED);
  - the kernel weight constants;
  - the INT_BITS rule.
- Sub-module img_lk_grad_sat handles shift plus clamp for one signed value and outputs a sat flag. It is instantiated three times: once for diff with shift 0, and twice for gx/gy with OUT_SHIFT.

## Test plan
Defaults RAW_BITS=8, GRAD_BITS=12, OUT_SHIFT=0 unless noted.
- **Ramp:** horizontal ramp s_raw[y][x][f]=10*x, both frames, Sobel. Expect gx=160, gy=0, diff=0, m_sat=0, exactly 5 enabled cycles later. Repeat in Scharr (expect gx=640) and in central difference (expect gx=40).
- **Saturation:** left column 0, right column 255 in both frames, Scharr. gx would be 8160, so expect gx=2047 and m_sat=1. Centre cur=200, prev=50: expect diff=150. With OUT_SHIFT=3: gx=1020, m_sat=0.
- **Mid-frame mode change:** frame start in Sobel, then s_mode=Scharr on later beats. All beats remain Sobel until the next s_user[0]. The beat carrying the new frame start uses Scharr.
- **Saturation count:** a frame of 10 beats, 3 of them saturating, followed by a frame start. Expect frame_sat_count=3 on the cycle after the new frame-start output beat.
- **cke stall:** a random cke pattern at 50% over a 100-beat stream. The output sequence is identical to the cke=1 run, and nothing is lost or duplicated.
- **Reset mid-stream:** assert reset_n=0 with 5 beats in flight. Expect m_valid=0 immediately, all outputs and frame_sat_count = 0, and mode = Sobel after release.
